// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT RX CRC scheduler: frame type codes and FSM encoding.
package sent_rx_pkg;

  localparam int NUM_TYPES = 5;

  localparam logic [2:0] TYPE_FAST6 = 3'd0;
  localparam logic [2:0] TYPE_FAST4 = 3'd1;
  localparam logic [2:0] TYPE_FAST3 = 3'd2;
  localparam logic [2:0] TYPE_SHORT = 3'd3;
  localparam logic [2:0] TYPE_ENH   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/sent_rx_prio_enc.sv
// Fixed-priority encoder over the per-type request vector; bit 0 (fast6) wins.
module sent_rx_prio_enc
  import sent_rx_pkg::*;
(
  input  logic [NUM_TYPES-1:0] req,
  output logic [2:0]           idx,
  output logic                 any
);

  always_comb begin
    any = |req;
    idx = TYPE_FAST6;
    if (req[0])      idx = TYPE_FAST6;
    else if (req[1]) idx = TYPE_FAST4;
    else if (req[2]) idx = TYPE_FAST3;
    else if (req[3]) idx = TYPE_SHORT;
    else if (req[4]) idx = TYPE_ENH;
  end

endmodule

// File: rtl/sent_rx_crc_scheduler.sv
// Queues one CRC request per SENT frame type and sequences the shared CRC checker.
// Handshake: crc_start is a one-cycle request; the checker answers with one crc_done pulse (crc_ok valid with it).
module sent_rx_crc_scheduler
  import sent_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic                 clk_rx,
  input  logic                 reset,
  input  logic [NUM_TYPES-1:0] done_pre_data,
  output logic                 crc_start,
  output logic [2:0]           crc_mode,
  input  logic                 crc_done,
  input  logic                 crc_ok,
  output logic                 result_valid,
  output logic [2:0]           result_type,
  output logic                 result_ok,
  output logic                 result_timeout,
  output logic [NUM_TYPES-1:0] pending,
  output logic [NUM_TYPES-1:0] overrun,
  input  logic [NUM_TYPES-1:0] overrun_clr,
  output logic [1:0]           state_dbg
);

  state_t               state_q, state_d;
  logic [NUM_TYPES-1:0] prev_q, pending_q, pending_d, overrun_q, overrun_d;
  logic [NUM_TYPES-1:0] fall, grant_mask;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [2:0]           mode_q, mode_d, grant_idx;
  logic                 grant_any;
  logic                 chk_ok_q, chk_ok_d, chk_tmo_q, chk_tmo_d;
  logic                 result_valid_q, result_valid_d;
  logic [2:0]           result_type_q, result_type_d;
  logic                 result_ok_q, result_ok_d, result_timeout_q, result_timeout_d;

  sent_rx_prio_enc u_prio_enc (
    .req (pending_q),
    .idx (grant_idx),
    .any (grant_any)
  );

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    tmo_cnt_d        = tmo_cnt_q;
    chk_ok_d         = chk_ok_q;
    chk_tmo_d        = chk_tmo_q;
    grant_mask       = '0;
    crc_start        = 1'b0;
    result_valid_d   = 1'b0;
    result_type_d    = result_type_q;
    result_ok_d      = result_ok_q;
    result_timeout_d = result_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          grant_mask = NUM_TYPES'(1) << grant_idx;
          mode_d     = grant_idx;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        crc_start = 1'b1;
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last timeout cycle still counts as a real answer.
        if (crc_done) begin
          chk_ok_d  = crc_ok;
          chk_tmo_d = 1'b0;
          state_d   = ST_REPORT;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          chk_ok_d  = 1'b0;
          chk_tmo_d = 1'b1;
          state_d   = ST_REPORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        result_valid_d   = 1'b1;
        result_type_d    = mode_q;
        result_ok_d      = chk_ok_q;
        result_timeout_d = chk_tmo_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame end always re-queues; overrun only when an unserved request is overwritten.
    fall      = prev_q & ~done_pre_data;
    pending_d = (pending_q & ~grant_mask) | fall;
    overrun_d = (overrun_q & ~overrun_clr) | (fall & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      prev_q           <= '0;
      pending_q        <= '0;
      overrun_q        <= '0;
      tmo_cnt_q        <= '0;
      mode_q           <= '0;
      chk_ok_q         <= 1'b0;
      chk_tmo_q        <= 1'b0;
      result_valid_q   <= 1'b0;
      result_type_q    <= '0;
      result_ok_q      <= 1'b0;
      result_timeout_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_q           <= done_pre_data;
      pending_q        <= pending_d;
      overrun_q        <= overrun_d;
      tmo_cnt_q        <= tmo_cnt_d;
      mode_q           <= mode_d;
      chk_ok_q         <= chk_ok_d;
      chk_tmo_q        <= chk_tmo_d;
      result_valid_q   <= result_valid_d;
      result_type_q    <= result_type_d;
      result_ok_q      <= result_ok_d;
      result_timeout_q <= result_timeout_d;
    end
  end

  assign crc_mode       = mode_q;
  assign result_valid   = result_valid_q;
  assign result_type    = result_type_q;
  assign result_ok      = result_ok_q;
  assign result_timeout = result_timeout_q;
  assign pending        = pending_q;
  assign overrun        = overrun_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_sent_rx_crc_scheduler.sv
// Directed bench for the SENT RX CRC scheduler: arbitration order, latency, overrun, timeout, reset.
module tb_sent_rx_crc_scheduler;

  logic       clk_rx;
  logic       reset;
  logic [4:0] done_pre_data;
  logic       crc_start;
  logic [2:0] crc_mode;
  logic       crc_done;
  logic       crc_ok;
  logic       result_valid;
  logic [2:0] result_type;
  logic       result_ok;
  logic       result_timeout;
  logic [4:0] pending;
  logic [4:0] overrun;
  logic [4:0] overrun_clr;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int res_cnt   = 0;
  logic [2:0] exp_q[$];

  sent_rx_crc_scheduler #(.TIMEOUT_CYCLES(64), .TMO_W(7)) dut (
    .clk_rx         (clk_rx),
    .reset          (reset),
    .done_pre_data  (done_pre_data),
    .crc_start      (crc_start),
    .crc_mode       (crc_mode),
    .crc_done       (crc_done),
    .crc_ok         (crc_ok),
    .result_valid   (result_valid),
    .result_type    (result_type),
    .result_ok      (result_ok),
    .result_timeout (result_timeout),
    .pending        (pending),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial begin
    clk_rx = 1'b0;
    forever #5 clk_rx = ~clk_rx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk_rx) begin
    if (crc_start)    start_cnt++;
    if (result_valid) res_cnt++;
  end

  task automatic tick();
    @(negedge clk_rx);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (crc_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(crc_start), 32'd1);
  endtask

  task automatic wait_result(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (result_valid !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk({tag, "_result_seen"}, 32'(result_valid), 32'd1);
  endtask

  task automatic pulse_fall(input logic [4:0] bits);
    done_pre_data = bits;
    tick();
    done_pre_data = 5'b0;
  endtask

  task automatic pulse_done(input logic ok);
    crc_done = 1'b1;
    crc_ok   = ok;
    tick();
    crc_done = 1'b0;
    crc_ok   = 1'b0;
  endtask

  initial begin
    int cyc;
    int snap_start, snap_res;
    logic [2:0] m;

    reset         = 1'b1;
    done_pre_data = 5'b0;
    crc_done      = 1'b0;
    crc_ok        = 1'b0;
    overrun_clr   = 5'b0;
    repeat (3) tick();
    chk("rst_start",   32'(crc_start), 32'd0);
    chk("rst_valid",   32'(result_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_mode",    32'(crc_mode), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // single fast6 frame with exact latency
    pulse_fall(5'b00001);
    tick();
    chk("t1_pending_set", 32'(pending), 32'h01);
    chk("t1_no_start_yet", 32'(crc_start), 32'd0);
    tick();
    chk("t1_start", 32'(crc_start), 32'd1);
    chk("t1_mode", 32'(crc_mode), 32'd0);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    tick();
    chk("t1_start_one_cycle", 32'(crc_start), 32'd0);
    repeat (8) tick();
    pulse_done(1'b1);
    chk("t1_valid_not_early", 32'(result_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(result_valid), 32'd1);
    chk("t1_type", 32'(result_type), 32'd0);
    chk("t1_ok", 32'(result_ok), 32'd1);
    chk("t1_tmo", 32'(result_timeout), 32'd0);
    tick();
    chk("t1_valid_pulse", 32'(result_valid), 32'd0);
    chk("t1_ok_held", 32'(result_ok), 32'd1);

    // simultaneous falls on bits 4,2,0 served in priority order
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    pulse_fall(5'b10101);
    tick();
    chk("t2_pending_all", 32'(pending), 32'h15);
    for (int i = 0; i < 3; i++) begin
      m = exp_q.pop_front();
      wait_start("t2", 8);
      chk("t2_mode", 32'(crc_mode), 32'(m));
      tick();
      pulse_done(1'b1);
      wait_result("t2", 5, cyc);
      chk("t2_type", 32'(result_type), 32'(m));
      chk("t2_ok", 32'(result_ok), 32'd1);
    end
    chk("t2_pending_empty", 32'(pending), 32'd0);
    chk("t2_no_overrun", 32'(overrun), 32'd0);

    // overrun on fast4 while its request is still queued
    done_pre_data = 5'b00011;
    tick();
    done_pre_data = 5'b00000;
    tick();
    done_pre_data = 5'b00010;
    tick();
    chk("t3_start_fast6", 32'(crc_start), 32'd1);
    chk("t3_mode_fast6", 32'(crc_mode), 32'd0);
    done_pre_data = 5'b00000;
    tick();
    chk("t3_overrun_set", 32'(overrun), 32'h02);
    chk("t3_pending_kept", 32'(pending), 32'h02);
    pulse_done(1'b0);
    wait_result("t3a", 5, cyc);
    chk("t3_type_a", 32'(result_type), 32'd0);
    chk("t3_ok_a", 32'(result_ok), 32'd0);
    tick();
    wait_start("t3b", 8);
    chk("t3_mode_fast4", 32'(crc_mode), 32'd1);
    tick();
    pulse_done(1'b1);
    wait_result("t3b", 5, cyc);
    chk("t3_type_b", 32'(result_type), 32'd1);
    chk("t3_overrun_sticky", 32'(overrun), 32'h02);
    overrun_clr = 5'b00010;
    tick();
    overrun_clr = 5'b00000;
    chk("t3_overrun_cleared", 32'(overrun), 32'd0);

    // timeout on a short serial check
    pulse_fall(5'b01000);
    wait_start("t4", 8);
    chk("t4_mode", 32'(crc_mode), 32'd3);
    wait_result("t4", 100, cyc);
    chk("t4_latency", 32'(cyc), 32'd66);
    chk("t4_type", 32'(result_type), 32'd3);
    chk("t4_tmo", 32'(result_timeout), 32'd1);
    chk("t4_ok", 32'(result_ok), 32'd0);

    // stray crc_done in IDLE ignored, then a mismatch
    tick();
    snap_res = res_cnt;
    pulse_done(1'b1);
    repeat (3) tick();
    chk("t5_idle_done_ignored", 32'(res_cnt), 32'(snap_res));
    chk("t5_no_start", 32'(crc_start), 32'd0);
    pulse_fall(5'b00100);
    wait_start("t5", 8);
    chk("t5_mode", 32'(crc_mode), 32'd2);
    repeat (3) tick();
    pulse_done(1'b0);
    wait_result("t5", 5, cyc);
    chk("t5_type", 32'(result_type), 32'd2);
    chk("t5_ok", 32'(result_ok), 32'd0);
    chk("t5_tmo", 32'(result_timeout), 32'd0);

    // reset mid-check with two requests still queued
    tick();
    pulse_fall(5'b00111);
    wait_start("t6", 8);
    tick();
    tick();
    chk("t6_pending_two", 32'(pending), 32'h06);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_start", 32'(crc_start), 32'd0);
    chk("t6_rst_mode", 32'(crc_mode), 32'd0);
    chk("t6_rst_valid", 32'(result_valid), 32'd0);
    chk("t6_rst_type", 32'(result_type), 32'd0);
    chk("t6_rst_ok", 32'(result_ok), 32'd0);
    chk("t6_rst_tmo", 32'(result_timeout), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    snap_start = start_cnt;
    snap_res   = res_cnt;
    repeat (80) tick();
    chk("t6_no_start_after", 32'(start_cnt), 32'(snap_start));
    chk("t6_no_result_after", 32'(res_cnt), 32'(snap_res));
    chk("t6_pending_after", 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
